pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Parametrised pipeline control unit for the 5-stage RV32 core, replacing the purely combinational decoder. It decodes the IF/ID instruction, owns the ID/EX control register, and generates stall, flush and PC-select from three hazard sources:
- load-use dependencies
- multi-cycle multiply
- taken branches with configurable flush depth

## Interface
Parameters:
- MUL_LATENCY, 3, EX cycles a mul occupies (≥1)
- FLUSH_DEPTH, 1, cycles IF/ID is flushed after a taken branch (≥1)
- REG_ADDR_W, 5, register index width

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous active-high reset
- inst_i  in  32  instruction in IF/ID
- inst_valid_i  in  1  IF/ID holds a real instruction
- beq_taken_i  in  1  EX comparator result for the beq in ID/EX
- alu_op_o  out  3  registered ALU op (lw 000, and 001, or 010, add/addi 011, sub 100, mul 101, beq 110, sw 111)
- alu_src_o  out  1  registered: 1 = immediate operand
- mem_rd_o  out  1  registered load
- mem_wr_o  out  1  registered store
- reg_wr_o  out  1  registered writeback enable
- rd_o  out  REG_ADDR_W  registered destination
- ctrl_valid_o  out  1  ID/EX holds a real instruction (0 = bubble)
- stall_o  out  1  hold PC and IF/ID
- flush_o  out  1  clear IF/ID
- pc_sel_o  out  1  select branch target
- illegal_o  out  1  one-cycle pulse: undecodable valid instruction entered ID/EX slot

## Operation
- Decode:
  - opcode 0110011 is R-type (funct3/funct7 select add/sub/mul/and/or).
  - 0010011 addi, 0000011 lw, 0100011 sw, 1100011 beq.
  - Anything else: bubble loaded, illegal_o=1.
- Bubble: ctrl_valid_o, reg_wr_o, mem_rd_o and mem_wr_o cleared; other fields don't-care.
- FSM states are RUN, MUL_WAIT and FLUSH, with a shared down-counter.
- RUN, priority high to low:
  1. Taken branch (ctrl_valid_o && alu_op_o==110 && beq_taken_i):
     - pc_sel_o=1 and flush_o=1 combinationally.
     - Bubble loaded.
     - If FLUSH_DEPTH>1: go to FLUSH, counter=FLUSH_DEPTH-1.
  2. Load-use (ctrl_valid_o && mem_rd_o && rd_o!=0 && rd_o matches rs1 of inst_i, or rs2 for R/sw/beq):
     - stall_o=1 combinationally.
     - Bubble loaded.
  3. Otherwise:
     - Decoded inst_i loaded if inst_valid_i, else bubble.
     - If a mul is loaded and MUL_LATENCY>1: go to MUL_WAIT, counter=MUL_LATENCY-1.
- MUL_WAIT:
  - stall_o=1; ID/EX held unchanged.
  - Counter decrements each cycle; return to RUN when it reaches 1.
- FLUSH:
  - flush_o=1; bubble loaded.
  - Counter decrements each cycle; return to RUN when it reaches 1.
  - pc_sel_o=0.
- A branch and a mul never coexist in ID/EX, so MUL_WAIT and a taken branch are mutually exclusive.

## Timing
- Reset:
  - Takes effect at the edge with rst_i=1; every output is 0 and state is RUN.
  - Reset mid-MUL_WAIT or mid-FLUSH aborts to RUN at that edge.
- Registered outputs update on the rising edge after decode; decode-to-ID/EX latency is 1 cycle.
- stall_o, flush_o and pc_sel_o are combinational from state and ID/EX contents, valid in the same cycle.
- Load-use costs exactly 1 stall cycle.
- A mul stalls the following instruction MUL_LATENCY-1 cycles.
- A taken branch costs FLUSH_DEPTH bubbles.
- illegal_o is asserted in the cycle after the edge that loads the bubble.
- An illegal instruction in IF/ID during a stall is not reported until it is actually consumed.

## Configuration
- PIPE_CTRL_MUL_EN defined:
  - funct7 0000001 decodes as mul (alu_op 101).
  - MUL_WAIT is present.
- Not defined:
  - mul encodings are illegal (bubble + illegal_o).
  - MUL_WAIT is removed; MUL_LATENCY is ignored.

## Test plan
- Reset then inst_i=0x002081B3 (add x3,x1,x2) valid → next cycle alu_op_o=011, reg_wr_o=1, rd_o=3, ctrl_valid_o=1, stall_o=0.
- Load-use:
  - Stimulus: 0x0000A283 (lw x5) followed by 0x00228333 (add x6,x5,x2).
  - Response: stall_o=1 for one cycle while lw is in ID/EX.
  - Response: one bubble (ctrl_valid_o=0), then add loads with rd_o=6.
- MUL_LATENCY=3 with PIPE_CTRL_MUL_EN:
  - Stimulus: 0x022083B3 (mul x7).
  - Response: alu_op_o=101 held 3 cycles, stall_o=1 for 2 cycles, then the next instruction loads.
- FLUSH_DEPTH=2:
  - Stimulus: 0x00208463 (beq) in ID/EX with beq_taken_i=1.
  - Response: pc_sel_o=1 for 1 cycle, flush_o=1 for 2 cycles, 2 bubbles.
  - Also check beq_taken_i=0 → no flush.
- Illegal input: 0xFFFFFFFF valid → illegal_o=1 for one cycle, ctrl_valid_o=0.
  - Without PIPE_CTRL_MUL_EN, 0x022083B3 behaves the same.
- Reset asserted during MUL_WAIT cycle 1 → next cycle stall_o=0, all outputs 0, and a new add decodes normally after release.

Source files
------------

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl
//  Brief    : RV32 ID-stage decoder, ID/EX control register and hazard unit
//             (load-use, multi-cycle mul, taken-branch flush).
//             Define PIPE_CTRL_MUL_EN to decode mul and enable MUL_WAIT.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter int MUL_LATENCY = 3,
    parameter int FLUSH_DEPTH = 1,
    parameter int REG_ADDR_W  = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           inst_i,
    input  logic                  inst_valid_i,
    input  logic                  beq_taken_i,
    output logic [2:0]            alu_op_o,
    output logic                  alu_src_o,
    output logic                  mem_rd_o,
    output logic                  mem_wr_o,
    output logic                  reg_wr_o,
    output logic [REG_ADDR_W-1:0] rd_o,
    output logic                  ctrl_valid_o,
    output logic                  stall_o,
    output logic                  flush_o,
    output logic                  pc_sel_o,
    output logic                  illegal_o
);

    localparam logic [6:0] c_OP_RTYPE = 7'b0110011;
    localparam logic [6:0] c_OP_ADDI  = 7'b0010011;
    localparam logic [6:0] c_OP_LW    = 7'b0000011;
    localparam logic [6:0] c_OP_SW    = 7'b0100011;
    localparam logic [6:0] c_OP_BEQ   = 7'b1100011;

    localparam logic [2:0] c_ALU_LW   = 3'b000;
    localparam logic [2:0] c_ALU_AND  = 3'b001;
    localparam logic [2:0] c_ALU_OR   = 3'b010;
    localparam logic [2:0] c_ALU_ADD  = 3'b011;
    localparam logic [2:0] c_ALU_SUB  = 3'b100;
    localparam logic [2:0] c_ALU_BEQ  = 3'b110;
    localparam logic [2:0] c_ALU_SW   = 3'b111;
`ifdef PIPE_CTRL_MUL_EN
    localparam logic [2:0] c_ALU_MUL  = 3'b101;
`endif

    localparam int c_CNT_MAX = (MUL_LATENCY > FLUSH_DEPTH) ? MUL_LATENCY : FLUSH_DEPTH;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
`ifdef PIPE_CTRL_MUL_EN
        MUL_WAIT = 2'd2,
`endif
        FLUSH    = 2'd1
    } state_t;

    typedef struct packed {
        logic                  valid;
        logic [2:0]            alu_op;
        logic                  alu_src;
        logic                  mem_rd;
        logic                  mem_wr;
        logic                  reg_wr;
        logic [REG_ADDR_W-1:0] rd;
    } ctrl_t;

    state_t               state_q, state_d;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;
    ctrl_t                ctrl_q, ctrl_d;
    logic                 illegal_q, illegal_d;

    ctrl_t                w_dec;
    logic                 w_dec_legal;
    logic                 w_uses_rs2;
    logic                 w_taken;
    logic                 w_load_use;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    assign w_opcode = inst_i[6:0];
    assign w_funct3 = inst_i[14:12];
    assign w_funct7 = inst_i[31:25];

    always_comb begin
        w_dec        = '0;
        w_dec.valid  = 1'b1;
        w_dec.rd     = REG_ADDR_W'(inst_i[11:7]);
        w_dec_legal  = 1'b1;
        w_uses_rs2   = 1'b0;
        case (w_opcode)
            c_OP_RTYPE: begin
                w_uses_rs2   = 1'b1;
                w_dec.reg_wr = 1'b1;
                if (w_funct7 == 7'b0000000 && w_funct3 == 3'b000)      w_dec.alu_op = c_ALU_ADD;
                else if (w_funct7 == 7'b0000000 && w_funct3 == 3'b111) w_dec.alu_op = c_ALU_AND;
                else if (w_funct7 == 7'b0000000 && w_funct3 == 3'b110) w_dec.alu_op = c_ALU_OR;
                else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000) w_dec.alu_op = c_ALU_SUB;
`ifdef PIPE_CTRL_MUL_EN
                else if (w_funct7 == 7'b0000001 && w_funct3 == 3'b000) w_dec.alu_op = c_ALU_MUL;
`endif
                else                                                   w_dec_legal  = 1'b0;
            end
            c_OP_ADDI: begin
                w_dec.alu_op  = c_ALU_ADD;
                w_dec.alu_src = 1'b1;
                w_dec.reg_wr  = 1'b1;
            end
            c_OP_LW: begin
                w_dec.alu_op  = c_ALU_LW;
                w_dec.alu_src = 1'b1;
                w_dec.mem_rd  = 1'b1;
                w_dec.reg_wr  = 1'b1;
            end
            c_OP_SW: begin
                w_uses_rs2    = 1'b1;
                w_dec.alu_op  = c_ALU_SW;
                w_dec.alu_src = 1'b1;
                w_dec.mem_wr  = 1'b1;
            end
            c_OP_BEQ: begin
                w_uses_rs2    = 1'b1;
                w_dec.alu_op  = c_ALU_BEQ;
            end
            default: w_dec_legal = 1'b0;
        endcase
        if (!w_dec_legal) begin
            w_dec = '0;
        end
    end

    // Hazard detection looks at the raw IF/ID fields, independent of legality.
    assign w_taken    = ctrl_q.valid && (ctrl_q.alu_op == c_ALU_BEQ) && beq_taken_i;
    assign w_load_use = ctrl_q.valid && ctrl_q.mem_rd && (ctrl_q.rd != '0) &&
                        ((ctrl_q.rd == REG_ADDR_W'(inst_i[19:15])) ||
                         (w_uses_rs2 && (ctrl_q.rd == REG_ADDR_W'(inst_i[24:20]))));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctrl_d    = ctrl_q;
        illegal_d = 1'b0;
        stall_o   = 1'b0;
        flush_o   = 1'b0;
        pc_sel_o  = 1'b0;
        case (state_q)
            RUN: begin
                if (w_taken) begin
                    pc_sel_o = 1'b1;
                    flush_o  = 1'b1;
                    ctrl_d   = '0;
                    if (FLUSH_DEPTH > 1) begin
                        state_d = FLUSH;
                        cnt_d   = c_CNT_W'(FLUSH_DEPTH - 1);
                    end
                end else if (w_load_use) begin
                    stall_o = 1'b1;
                    ctrl_d  = '0;
                end else begin
                    ctrl_d    = inst_valid_i ? w_dec : '0;
                    illegal_d = inst_valid_i && !w_dec_legal;
`ifdef PIPE_CTRL_MUL_EN
                    if (inst_valid_i && w_dec_legal && (w_dec.alu_op == c_ALU_MUL) &&
                        (MUL_LATENCY > 1)) begin
                        state_d = MUL_WAIT;
                        cnt_d   = c_CNT_W'(MUL_LATENCY - 1);
                    end
`endif
                end
            end
`ifdef PIPE_CTRL_MUL_EN
            MUL_WAIT: begin
                stall_o = 1'b1;
                cnt_d   = cnt_q - c_CNT_W'(1);
                if (cnt_q <= c_CNT_W'(1)) begin
                    state_d = RUN;
                end
            end
`endif
            FLUSH: begin
                flush_o = 1'b1;
                ctrl_d  = '0;
                cnt_d   = cnt_q - c_CNT_W'(1);
                if (cnt_q <= c_CNT_W'(1)) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
        end
    end

    assign alu_op_o     = ctrl_q.alu_op;
    assign alu_src_o    = ctrl_q.alu_src;
    assign mem_rd_o     = ctrl_q.mem_rd;
    assign mem_wr_o     = ctrl_q.mem_wr;
    assign reg_wr_o     = ctrl_q.reg_wr;
    assign rd_o         = ctrl_q.rd;
    assign ctrl_valid_o = ctrl_q.valid;
    assign illegal_o    = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_ctrl
//  Brief    : Scoreboard bench for pipe_ctrl: directed scenarios plus random
//             instruction streams against a cycle-count reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    localparam int MUL_LATENCY = 3;
    localparam int FLUSH_DEPTH = 2;
    localparam int REG_ADDR_W  = 5;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] inst_i = '0;
    logic        inst_valid_i = 1'b0;
    logic        beq_taken_i = 1'b0;
    logic [2:0]  alu_op_o;
    logic        alu_src_o, mem_rd_o, mem_wr_o, reg_wr_o;
    logic [REG_ADDR_W-1:0] rd_o;
    logic        ctrl_valid_o, stall_o, flush_o, pc_sel_o, illegal_o;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .MUL_LATENCY(MUL_LATENCY),
        .FLUSH_DEPTH(FLUSH_DEPTH),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .inst_i      (inst_i),
        .inst_valid_i(inst_valid_i),
        .beq_taken_i (beq_taken_i),
        .alu_op_o    (alu_op_o),
        .alu_src_o   (alu_src_o),
        .mem_rd_o    (mem_rd_o),
        .mem_wr_o    (mem_wr_o),
        .reg_wr_o    (reg_wr_o),
        .rd_o        (rd_o),
        .ctrl_valid_o(ctrl_valid_o),
        .stall_o     (stall_o),
        .flush_o     (flush_o),
        .pc_sel_o    (pc_sel_o),
        .illegal_o   (illegal_o)
    );

    typedef struct packed {
        logic       valid;
        logic [2:0] op;
        logic       src;
        logic       rdm;
        logic       wrm;
        logic       regwr;
        logic [4:0] rd;
    } ctrl_t;

    typedef struct packed {
        ctrl_t c;
        logic  ill;
        logic  stall;
        logic  flush;
        logic  pcsel;
        logic  full;
    } exp_t;

    typedef struct packed {
        logic        rst;
        logic        vld;
        logic [31:0] ins;
    } item_t;

    exp_t  exp_q[$];
    item_t prog[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    taken_mode = 0;

    // Reference model: ID/EX contents plus remaining stall/flush cycles.
    ctrl_t m_ctrl = '0;
    logic  m_illegal = 1'b0;
    logic  m_full = 1'b1;
    int    m_mul_left = 0;
    int    m_flush_left = 0;

    function automatic void tb_decode(input logic [31:0] ins, output ctrl_t c, output bit legal);
        c = '0;
        legal = 1'b1;
        c.valid = 1'b1;
        c.rd = ins[11:7];
        case (ins[6:0])
            7'b0110011: begin
                c.regwr = 1'b1;
                case ({ins[31:25], ins[14:12]})
                    {7'h00, 3'd0}: c.op = 3'b011;
                    {7'h00, 3'd7}: c.op = 3'b001;
                    {7'h00, 3'd6}: c.op = 3'b010;
                    {7'h20, 3'd0}: c.op = 3'b100;
`ifdef PIPE_CTRL_MUL_EN
                    {7'h01, 3'd0}: c.op = 3'b101;
`endif
                    default: legal = 1'b0;
                endcase
            end
            7'b0010011: begin c.op = 3'b011; c.src = 1'b1; c.regwr = 1'b1; end
            7'b0000011: begin c.op = 3'b000; c.src = 1'b1; c.regwr = 1'b1; c.rdm = 1'b1; end
            7'b0100011: begin c.op = 3'b111; c.src = 1'b1; c.wrm = 1'b1; end
            7'b1100011: begin c.op = 3'b110; end
            default: legal = 1'b0;
        endcase
        if (!legal) c = '0;
    endfunction

    function automatic bit reads_rs2(input logic [31:0] ins);
        return (ins[6:0] == 7'b0110011) || (ins[6:0] == 7'b0100011) || (ins[6:0] == 7'b1100011);
    endfunction

    task automatic model_step(input bit rst, input logic [31:0] ins, input bit vld,
                              input bit tk, output exp_t e);
        ctrl_t nxt, c;
        bit    nill, legal, lu;
        e = '0;
        e.c = m_ctrl;
        e.ill = m_illegal;
        e.full = m_full;
        nxt = m_ctrl;
        nill = 1'b0;
        lu = m_ctrl.valid && m_ctrl.rdm && (m_ctrl.rd != 5'd0) &&
             ((m_ctrl.rd == ins[19:15]) || (reads_rs2(ins) && (m_ctrl.rd == ins[24:20])));
        if (m_mul_left > 0) begin
            e.stall = 1'b1;
            m_mul_left--;
        end else if (m_flush_left > 0) begin
            e.flush = 1'b1;
            nxt = '0;
            m_flush_left--;
        end else if (m_ctrl.valid && m_ctrl.op == 3'b110 && tk) begin
            e.flush = 1'b1;
            e.pcsel = 1'b1;
            nxt = '0;
            m_flush_left = FLUSH_DEPTH - 1;
        end else if (lu) begin
            e.stall = 1'b1;
            nxt = '0;
        end else if (vld) begin
            tb_decode(ins, c, legal);
            nxt = c;
            nill = !legal;
            if (legal && c.op == 3'b101) m_mul_left = MUL_LATENCY - 1;
        end else begin
            nxt = '0;
        end
        if (rst) begin
            nxt = '0;
            nill = 1'b0;
            m_mul_left = 0;
            m_flush_left = 0;
        end
        m_ctrl = nxt;
        m_illegal = nill;
        m_full = rst;
    endtask

    task automatic drive(input bit rst, input logic [31:0] ins, input bit vld, output exp_t e);
        bit tk;
        @(posedge clk);
        #1;
        tk = (taken_mode == 1) ? 1'b1 : (taken_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        rst_i = rst;
        inst_i = ins;
        inst_valid_i = vld;
        beq_taken_i = tk;
        model_step(rst, ins, vld, tk, e);
        exp_q.push_back(e);
    endtask

    // Presents the program as a fetch stage would: hold on stall, empty slot after a flush.
    task automatic run_prog();
        exp_t  e;
        item_t it;
        bit    last_flush = 1'b0;
        while (prog.size() > 0) begin
            it = prog[0];
            if (last_flush && !it.rst) begin
                drive(1'b0, 32'h0, 1'b0, e);
            end else begin
                drive(it.rst, it.ins, it.vld, e);
                if (it.rst || !e.stall) void'(prog.pop_front());
            end
            last_flush = e.flush;
        end
    endtask

    function automatic void push_i(input logic [31:0] ins);
        prog.push_back('{rst: 1'b0, vld: 1'b1, ins: ins});
    endfunction

    function automatic void push_inv(input int n);
        for (int i = 0; i < n; i++) prog.push_back('{rst: 1'b0, vld: 1'b0, ins: 32'h0});
    endfunction

    function automatic void push_rst();
        prog.push_back('{rst: 1'b1, vld: 1'b0, ins: 32'h0});
    endfunction

    function automatic logic [4:0] pick_reg();
        logic [4:0] pool [5];
        pool = '{5'd0, 5'd1, 5'd2, 5'd5, 5'd31};
        return pool[$urandom_range(0, 4)];
    endfunction

    function automatic logic [31:0] rnd_inst();
        logic [4:0] rd, rs1, rs2;
        logic [11:0] imm;
        rd  = pick_reg();
        rs1 = pick_reg();
        rs2 = pick_reg();
        imm = 12'($urandom);
        case ($urandom_range(0, 12))
            0:       return {7'h00, rs2, rs1, 3'd0, rd, 7'b0110011};
            1:       return {7'h20, rs2, rs1, 3'd0, rd, 7'b0110011};
            2:       return {7'h00, rs2, rs1, 3'd7, rd, 7'b0110011};
            3:       return {7'h00, rs2, rs1, 3'd6, rd, 7'b0110011};
            4, 5:    return {7'h01, rs2, rs1, 3'd0, rd, 7'b0110011};
            6:       return {imm, rs1, 3'd0, rd, 7'b0010011};
            7, 8:    return {imm, rs1, 3'd2, rd, 7'b0000011};
            9:       return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'b0100011};
            10:      return {7'h00, rs2, rs1, 3'd0, imm[4:0], 7'b1100011};
            11:      return {7'h20, rs2, rs1, 3'd7, rd, 7'b0110011};
            default: return $urandom;
        endcase
    endfunction

    // Monitor: pops one expectation per cycle and compares on the falling edge.
    initial begin
        exp_t        e;
        logic [16:0] act, expv, mask;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cyc++;
                act  = {alu_op_o, alu_src_o, mem_rd_o, mem_wr_o, reg_wr_o, rd_o,
                        ctrl_valid_o, stall_o, flush_o, pc_sel_o, illegal_o};
                expv = {e.c.op, e.c.src, e.c.rdm, e.c.wrm, e.c.regwr, e.c.rd,
                        e.c.valid, e.stall, e.flush, e.pcsel, e.ill};
                if (e.full) mask = '1;
                else begin
                    mask = 17'h01C1F;
                    if (e.c.valid) mask = mask | 17'h1E000;
                    if (e.c.valid && e.c.regwr) mask = mask | 17'h003E0;
                end
                n_checks++;
                if ((act & mask) !== (expv & mask)) begin
                    n_fail++;
                    $display("FAIL cycle %0d outputs {op,src,mrd,mwr,rwr,rd,vld,stall,flush,pcsel,ill}: got %b expected %b mask %b",
                             cyc, act, expv, mask);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);

        push_i(32'h002081B3);                      // add x3,x1,x2
        push_inv(2);
        push_i(32'h0000A283);                      // lw x5
        push_i(32'h00228333);                      // add x6,x5,x2
        push_inv(2);
        push_i(32'h022083B3);                      // mul x7
        push_i(32'h002081B3);
        push_inv(2);
        run_prog();

        taken_mode = 1;
        push_i(32'h00208463);                      // beq, taken
        push_i(32'h002081B3);
        push_i(32'h002081B3);
        push_i(32'h002081B3);
        push_inv(2);
        run_prog();
        taken_mode = 0;
        push_i(32'h00208463);                      // beq, not taken
        push_i(32'h002081B3);
        push_inv(2);
        push_i(32'hFFFFFFFF);
        push_inv(2);
        push_i({12'h0, 5'd1, 3'd2, 5'd31, 7'b0000011});  // lw x31 then illegal reading x31
        push_i(32'hFFFFFFFF);
        push_inv(2);
        push_i(32'h022083B3);                      // mul, then reset in the first wait cycle
        push_rst();
        push_i(32'h002081B3);
        push_inv(2);
        run_prog();

        taken_mode = 2;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) == 0) push_rst();
            else if ($urandom_range(0, 9) == 0) push_inv(1);
            else push_i(rnd_inst());
        end
        run_prog();

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
